// File: rtl/classificador_botao_pkg.sv
// Shared types and default timing for the button gesture classifier.
// State encoding, default tick counts and a small max helper.
package classificador_botao_pkg;

    localparam logic [2:0] ST_OCIOSO = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_ESPERA = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONGO  = 3'd4;

    typedef enum logic [2:0] {
        OCIOSO = ST_OCIOSO,
        PRESS1 = ST_PRESS1,
        ESPERA = ST_ESPERA,
        PRESS2 = ST_PRESS2,
        LONGO  = ST_LONGO
    } estado_t;

    localparam int CNT_W_PAD    = 26;
    localparam int T_LONGO_PAD  = 25_000_000;
    localparam int T_DUPLO_PAD  = 10_000_000;
    localparam int T_REPETE_PAD = 5_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/classificador_botao_contador.sv
// contador_janela: saturating up-counter with sync clear / load-one.
// Ports: clk, rst_n, clr, carga1 in; fim_longo, fim_duplo (and
// fim_repete with CLASSIFICADOR_BOTAO_REPETE_EN) compare flags out.
module contador_janela #(
    parameter int CNT_W      = 26,
    parameter int LIM_LONGO  = 24_999_999,
    parameter int LIM_DUPLO  = 9_999_999,
`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
    parameter int LIM_REPETE = 4_999_999,
`endif
    parameter int LIM_SAT    = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic carga1,
`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
    output logic fim_repete,
`endif
    output logic fim_longo,
    output logic fim_duplo
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(LIM_SAT);
    localparam logic [CNT_W-1:0] LL  = CNT_W'(LIM_LONGO);
    localparam logic [CNT_W-1:0] LD  = CNT_W'(LIM_DUPLO);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counting stops above the largest compare point, so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (carga1) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim_longo = (cnt_q == LL);
    assign fim_duplo = (cnt_q == LD);
`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
    assign fim_repete = (cnt_q == CNT_W'(LIM_REPETE));
`endif

endmodule

// File: rtl/classificador_botao.sv
// Classifies a debounced button into short/long/double one-cycle events.
// Ports: clk, rst_n, b_in in; ev_curto, ev_longo, ev_duplo, ocupado out.
// Option CLASSIFICADOR_BOTAO_REPETE_EN: auto-repeat ev_longo while held.
module classificador_botao
    import classificador_botao_pkg::*;
#(
    parameter int CNT_W    = CNT_W_PAD,
    parameter int T_LONGO  = T_LONGO_PAD,
    parameter int T_DUPLO  = T_DUPLO_PAD,
    parameter int T_REPETE = T_REPETE_PAD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic b_in,
    output logic ev_curto,
    output logic ev_longo,
    output logic ev_duplo,
    output logic ocupado
);

    estado_t state_q, state_d;
    logic    b_prev_q;
    logic    ev_curto_q, ev_curto_d;
    logic    ev_longo_q, ev_longo_d;
    logic    ev_duplo_q, ev_duplo_d;
    logic    ocupado_q;
    logic    clr, carga1;
    logic    fim_longo, fim_duplo;
    logic    sobe;

`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
    logic rep_ok_q, rep_ok_d;
    logic fim_repete;
`endif

    assign sobe = b_in && !b_prev_q;

    contador_janela #(
        .CNT_W      (CNT_W),
        .LIM_LONGO  (T_LONGO - 1),
        .LIM_DUPLO  (T_DUPLO - 1),
`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
        .LIM_REPETE (T_REPETE - 1),
`endif
        .LIM_SAT    (max3(T_LONGO, T_DUPLO, T_REPETE))
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .carga1     (carga1),
`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
        .fim_repete (fim_repete),
`endif
        .fim_longo  (fim_longo),
        .fim_duplo  (fim_duplo)
    );

    // Press phases count their opening edge sample, so the counter
    // loads 1 there; a long press fires on its T_LONGO-th high sample.
    always_comb begin
        state_d    = state_q;
        ev_curto_d = 1'b0;
        ev_longo_d = 1'b0;
        ev_duplo_d = 1'b0;
        clr        = 1'b0;
        carga1     = 1'b0;
`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
        rep_ok_d   = rep_ok_q;
`endif
        unique case (state_q)
            OCIOSO: begin
                if (sobe) begin
                    state_d = PRESS1;
                    carga1  = 1'b1;
                end
            end
            PRESS1: begin
                if (!b_in) begin
                    state_d = ESPERA;
                    clr     = 1'b1;
                end else if (fim_longo) begin
                    state_d    = LONGO;
                    ev_longo_d = 1'b1;
                    clr        = 1'b1;
`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
                    rep_ok_d   = 1'b1;
`endif
                end
            end
            ESPERA: begin
                if (b_in) begin
                    state_d = PRESS2;
                    carga1  = 1'b1;
                end else if (fim_duplo) begin
                    state_d    = OCIOSO;
                    ev_curto_d = 1'b1;
                    clr        = 1'b1;
                end
            end
            PRESS2: begin
                if (!b_in) begin
                    state_d    = OCIOSO;
                    ev_duplo_d = 1'b1;
                    clr        = 1'b1;
                end else if (fim_longo) begin
                    state_d    = LONGO;
                    ev_duplo_d = 1'b1;
                    clr        = 1'b1;
`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
                    rep_ok_d   = 1'b0;
`endif
                end
            end
            LONGO: begin
                if (!b_in) begin
                    state_d = OCIOSO;
                    clr     = 1'b1;
`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
                end else if (rep_ok_q && fim_repete) begin
                    // Restart the window so ticks are T_REPETE apart.
                    ev_longo_d = 1'b1;
                    clr        = 1'b1;
`endif
                end
            end
            default: begin
                state_d = OCIOSO;
                clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OCIOSO;
            b_prev_q   <= 1'b1;
            ev_curto_q <= 1'b0;
            ev_longo_q <= 1'b0;
            ev_duplo_q <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_prev_q   <= b_in;
            ev_curto_q <= ev_curto_d;
            ev_longo_q <= ev_longo_d;
            ev_duplo_q <= ev_duplo_d;
            ocupado_q  <= (state_d != OCIOSO);
        end
    end

`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_ok_q <= 1'b0;
        end else begin
            rep_ok_q <= rep_ok_d;
        end
    end
`endif

    assign ev_curto = ev_curto_q;
    assign ev_longo = ev_longo_q;
    assign ev_duplo = ev_duplo_q;
    assign ocupado  = ocupado_q;

endmodule

// File: tb/tb_classificador_botao.sv
// Directed bench for classificador_botao with short timing constants.
// Event vectors are {ev_curto, ev_longo, ev_duplo}.
module tb_classificador_botao;

    logic clk;
    logic rst_n;
    logic b_in;
    logic ev_curto, ev_longo, ev_duplo, ocupado;

    int n_vec;
    int n_err;

`ifdef CLASSIFICADOR_BOTAO_REPETE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    classificador_botao #(
        .CNT_W    (8),
        .T_LONGO  (8),
        .T_DUPLO  (4),
        .T_REPETE (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .b_in     (b_in),
        .ev_curto (ev_curto),
        .ev_longo (ev_longo),
        .ev_duplo (ev_duplo),
        .ocupado  (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs,
                       input logic [2:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One sample of b_in; checks the events produced by that sample.
    task automatic passo(input string tag, input logic b,
                         input logic [2:0] exp);
        b_in = b;
        @(posedge clk);
        #1;
        chk(tag, {ev_curto, ev_longo, ev_duplo}, exp);
    endtask

    task automatic chk_ocup(input string tag, input logic exp);
        chk(tag, {2'b00, ocupado}, {2'b00, exp});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        b_in  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_ev", {ev_curto, ev_longo, ev_duplo}, 3'b000);
        chk_ocup("reset_ocup", 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) passo("idle", 1'b0, 3'b000);

        // 1: short press
        for (int i = 0; i < 3; i++) passo("t1_high", 1'b1, 3'b000);
        chk_ocup("t1_ocup", 1'b1);
        for (int i = 0; i < 4; i++) passo("t1_wait", 1'b0, 3'b000);
        passo("t1_curto", 1'b0, 3'b100);
        chk_ocup("t1_ocup_end", 1'b0);
        passo("t1_after", 1'b0, 3'b000);

        // 2: long press, 12 samples
        for (int i = 1; i <= 12; i++) begin
            if (i == 8 || (REP && i == 11))
                passo("t2_longo", 1'b1, 3'b010);
            else
                passo("t2_hold", 1'b1, 3'b000);
        end
        chk_ocup("t2_ocup_held", 1'b1);
        passo("t2_release", 1'b0, 3'b000);
        chk_ocup("t2_ocup_rel", 1'b0);
        for (int i = 0; i < 6; i++) passo("t2_idle", 1'b0, 3'b000);

        // 3: double press
        passo("t3_h1", 1'b1, 3'b000);
        passo("t3_h1", 1'b1, 3'b000);
        passo("t3_l1", 1'b0, 3'b000);
        passo("t3_l1", 1'b0, 3'b000);
        passo("t3_h2", 1'b1, 3'b000);
        passo("t3_h2", 1'b1, 3'b000);
        passo("t3_duplo", 1'b0, 3'b001);
        chk_ocup("t3_ocup", 1'b0);
        for (int i = 0; i < 6; i++) passo("t3_idle", 1'b0, 3'b000);

        // 4: button held through reset is ignored
        b_in  = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) passo("t4_held", 1'b1, 3'b000);
        chk_ocup("t4_ocup_held", 1'b0);
        for (int i = 0; i < 8; i++) passo("t4_idle", 1'b0, 3'b000);
        passo("t4_p", 1'b1, 3'b000);
        passo("t4_p", 1'b1, 3'b000);
        for (int i = 0; i < 4; i++) passo("t4_wait", 1'b0, 3'b000);
        passo("t4_curto", 1'b0, 3'b100);

        // 5: reset mid-gesture
        passo("t5_h", 1'b1, 3'b000);
        passo("t5_h", 1'b1, 3'b000);
        passo("t5_l", 1'b0, 3'b000);
        passo("t5_l", 1'b0, 3'b000);
        chk_ocup("t5_ocup_pre", 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ev", {ev_curto, ev_longo, ev_duplo}, 3'b000);
        chk_ocup("t5_rst_ocup", 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) passo("t5_idle", 1'b0, 3'b000);

        // 6: 15-sample hold, repeat ticks only with the option
        for (int i = 1; i <= 15; i++) begin
            if (i == 8 || (REP && (i == 11 || i == 14)))
                passo("t6_longo", 1'b1, 3'b010);
            else
                passo("t6_hold", 1'b1, 3'b000);
        end
        passo("t6_release", 1'b0, 3'b000);
        for (int i = 0; i < 6; i++) passo("t6_idle", 1'b0, 3'b000);

        // 7: release on the long-press boundary sample
        for (int i = 0; i < 7; i++) passo("t7_hold", 1'b1, 3'b000);
        passo("t7_tie", 1'b0, 3'b000);
        chk_ocup("t7_ocup", 1'b1);
        for (int i = 0; i < 3; i++) passo("t7_wait", 1'b0, 3'b000);
        passo("t7_curto", 1'b0, 3'b100);
        passo("t7_after", 1'b0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
